// File: rtl/conv_window_ctrl_pkg.sv
// Shared definitions for the 3x3 window controller: FSM encoding, window
// geometry and the helper that flattens a window into the mac_unit word.
package conv_window_ctrl_pkg;

    localparam int PIX_W    = 8;
    localparam int KSIZE    = 3;
    localparam int WIN_TAPS = KSIZE * KSIZE;
    localparam int WIN_BITS = PIX_W * WIN_TAPS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef logic [PIX_W-1:0] pix_t;

    // Indexed [row][col]; row 0 is the oldest line, col 0 the leftmost pixel.
    typedef pix_t [KSIZE-1:0][KSIZE-1:0] win_t;

    // Row-major flattening with the top-left pixel in the most significant byte.
    function automatic logic [WIN_BITS-1:0] pack_window(input win_t w);
        logic [WIN_BITS-1:0] flat;
        flat = '0;
        for (int r = 0; r < KSIZE; r++) begin
            for (int c = 0; c < KSIZE; c++) begin
                flat[WIN_BITS-1-(r*KSIZE+c)*PIX_W -: PIX_W] = w[r][c];
            end
        end
        return flat;
    endfunction

endpackage

// File: rtl/conv_window_ctrl_line_buffer.sv
// One image line of delay: a DEPTH-deep shift register that advances only on
// accepted pixels, so dout_o is the pixel from the same column one line above.
// Contents are never reset; stale data is never used for an issued window.
module line_buffer
    import conv_window_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = PIX_W,
    parameter int DEPTH      = 64
) (
    input  logic                  clk,
    input  logic                  shift_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    output logic [DATA_WIDTH-1:0] dout_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Shift one position per accepted pixel.
    always_ff @(posedge clk) begin
        if (shift_i) begin
            mem_q[0] <= din_i;
            for (int i = 1; i < DEPTH; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    assign dout_o = mem_q[DEPTH-1];

endmodule

// File: rtl/conv_window_ctrl.sv
// Frame controller for the 3x3 MAC path: buffers two lines of a raster pixel
// stream, issues every fully-inside 3x3 window to mac_unit, registers the
// returned results, tags the last one of the frame and pulses frame_done.
// DATA_WIDTH must match the package pixel width (window packing is fixed).
module conv_window_ctrl
    import conv_window_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = PIX_W,
    parameter int KERNEL_SIZE = KSIZE,
    parameter int IMG_WIDTH   = 64,
    parameter int IMG_HEIGHT  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] pix_in,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    output logic [WIN_BITS-1:0]   win_data,
    output logic                  win_valid,
    input  logic [DATA_WIDTH-1:0] mac_result,
    input  logic                  mac_valid,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic                  res_valid,
    output logic                  res_last,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int N     = (IMG_WIDTH - KERNEL_SIZE + 1) * (IMG_HEIGHT - KERNEL_SIZE + 1);
    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    state_e                state_q, state_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    win_t                  win_q, win_d;
    logic                  win_valid_q, win_valid_d;
    logic [WIN_BITS-1:0]   win_data_q, win_data_d;
    logic                  res_valid_q, res_valid_d;
    logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
    logic                  res_last_q, res_last_d;

    logic                  accept;
    logic                  last_pix;
    logic                  issue;
    logic                  mac_ok;
    logic [DATA_WIDTH-1:0] lb_r1;
    logic [DATA_WIDTH-1:0] lb_r2;

    assign accept   = pix_valid && (state_q == ST_RUN);
    assign last_pix = accept && (row_q == ROW_W'(IMG_HEIGHT-1)) && (col_q == COL_W'(IMG_WIDTH-1));
    // Only windows whose three columns all belong to the current line are issued.
    assign issue    = accept && (row_q >= ROW_W'(KERNEL_SIZE-1)) && (col_q >= COL_W'(KERNEL_SIZE-1));
    assign mac_ok   = mac_valid && ((state_q == ST_RUN) || (state_q == ST_DRAIN));

    // Cascaded line delays: first tap is row r-1, second is row r-2.
    line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_lb_r1 (
        .clk     (clk),
        .shift_i (accept),
        .din_i   (pix_in),
        .dout_o  (lb_r1)
    );

    line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_lb_r2 (
        .clk     (clk),
        .shift_i (accept),
        .din_i   (lb_r1),
        .dout_o  (lb_r2)
    );

    // Next state and status outputs of the frame FSM.
    always_comb begin
        state_d    = state_q;
        pix_ready  = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                pix_ready = 1'b1;
                busy      = 1'b1;
                if (last_pix) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (res_last_q) state_d = ST_DONE;
            end
            ST_DONE: begin
                frame_done = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Raster position and result counters; all restart when a frame starts.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        cnt_d = cnt_q;
        if ((state_q == ST_IDLE) && start) begin
            col_d = '0;
            row_d = '0;
            cnt_d = '0;
        end else begin
            if (accept) begin
                if (col_q == COL_W'(IMG_WIDTH-1)) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            if (mac_ok) cnt_d = cnt_q + 1'b1;
        end
    end

    // Window shift (new column enters on the right) and output staging.
    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int r = 0; r < KSIZE; r++) begin
                for (int c = 0; c < KSIZE-1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
            end
            win_d[0][KSIZE-1] = lb_r2;
            win_d[1][KSIZE-1] = lb_r1;
            win_d[2][KSIZE-1] = pix_in;
        end
        win_valid_d = issue;
        win_data_d  = issue ? pack_window(win_d) : win_data_q;
        res_valid_d = mac_ok;
        res_data_d  = mac_ok ? mac_result : res_data_q;
        res_last_d  = mac_ok && (cnt_q == CNT_W'(N-1));
    end

    // State, counters and window/result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            cnt_q       <= '0;
            win_q       <= '0;
            win_valid_q <= 1'b0;
            win_data_q  <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            win_q       <= win_d;
            win_valid_q <= win_valid_d;
            win_data_q  <= win_data_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_last_q  <= res_last_d;
        end
    end

    assign win_valid = win_valid_q;
    assign win_data  = win_data_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_last  = res_last_q;

endmodule
